// File: rtl/uram_arb_pkg.sv
// Shared constants, the sleep FSM state type and an index-width helper
// for the URAM port arbiter.
package uram_arb_pkg;

  localparam int URAM_BE_W = 9;
  localparam int URAM_DW   = 72;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: combinational one-hot pick starting at a
// registered pointer; the pointer moves past each winner and holds otherwise.
module rr_pick
  import uram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      win_idx,
  output logic               win_any
);

  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] req_hi;

  // Requests at or above the pointer take precedence over wrapped ones.
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_hi[i] = req[i] && (IW'(i) >= ptr);
    end
  end

  // Lowest request in the upper window wins; otherwise lowest overall.
  always_comb begin
    win_idx = '0;
    win_any = en && (|req);
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IW'(i);
    end
    if (|req_hi) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_hi[i]) win_idx = IW'(i);
      end
    end
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = win_any && (win_idx == IW'(i));
    end
  end

  // Pointer advances to winner+1 (wrapping) and holds on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (win_any) begin
      ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uram_port_arbiter.sv
// Round-robin arbiter sharing one URAM288 port among NUM_REQ requesters.
// Grants are combinational; read responses are tagged with the requester
// index through a {valid,id} pipeline matching the URAM read latency.
// Optional build macro URAM_ARB_SLEEP_EN adds an idle-driven sleep/wake FSM.
module uram_port_arbiter
  import uram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int AWIDTH      = 12,
  parameter int DWIDTH      = URAM_DW,
  parameter int MEM_LATENCY = 1,
  parameter int SLEEP_IDLE  = 64,
  parameter int WAKE_CYCLES = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*URAM_BE_W-1:0]   req_be,
  input  logic [NUM_REQ*AWIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           rsp_valid,
  output logic [IW-1:0]                  rsp_id,
  output logic [DWIDTH-1:0]              rsp_data,
  output logic                           mem_en,
  output logic [URAM_BE_W-1:0]           mem_we,
  output logic [AWIDTH-1:0]              mem_addr,
  output logic [DWIDTH-1:0]              mem_din,
  input  logic [DWIDTH-1:0]              mem_dout,
  output logic                           mem_sleep
);

  localparam int DEPTH = MEM_LATENCY + 1;

  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             win_we;
  logic             grant_ok;
  logic [DEPTH-1:0] tag_vld_p;
  logic [IW-1:0]    tag_id_p [DEPTH];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .en      (grant_ok),
    .gnt     (gnt),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Steer the winning requester's fields onto the URAM port.
  always_comb begin
    win_we   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_we   = req_we[i];
        mem_we   = req_we[i] ? req_be[i*URAM_BE_W +: URAM_BE_W] : '0;
        mem_addr = req_addr[i*AWIDTH +: AWIDTH];
        mem_din  = req_wdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign mem_en = win_any;

  // Tag pipeline: p0 captures the granted read, last stage meets douta.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_p <= '0;
      for (int s = 0; s < DEPTH; s++) tag_id_p[s] <= '0;
    end else begin
      tag_vld_p[0] <= win_any && !win_we;
      tag_id_p[0]  <= win_idx;
      for (int s = 1; s < DEPTH; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_id_p[s]  <= tag_id_p[s-1];
      end
    end
  end

  assign rsp_valid = tag_vld_p[DEPTH-1];
  assign rsp_id    = tag_id_p[DEPTH-1];
  assign rsp_data  = mem_dout;

`ifdef URAM_ARB_SLEEP_EN
  localparam int ICW = $clog2(SLEEP_IDLE + 1);
  localparam int WCW = $clog2(WAKE_CYCLES + 1);

  arb_state_e     state, state_nxt;
  logic [ICW-1:0] idle_cnt;
  logic [WCW-1:0] wake_cnt;
  logic           idle;

  assign idle = ~|req && ~|tag_vld_p;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACTIVE;
    else        state <= state_nxt;
  end

  // Next state; the SLEEP exit cycle counts as the first blocked wake cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACTIVE: if (idle && idle_cnt == ICW'(SLEEP_IDLE - 1)) state_nxt = SLEEP;
      SLEEP:  if (|req) state_nxt = (WAKE_CYCLES > 1) ? WAKE : ACTIVE;
      WAKE:   if (wake_cnt <= WCW'(1)) state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
  end

  // Outputs: sleep drops as soon as a request appears; grants only in ACTIVE.
  always_comb begin
    grant_ok  = (state == ACTIVE);
    mem_sleep = (state == SLEEP) && ~|req;
  end

  // Idle and wake counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      idle_cnt <= (state == ACTIVE && idle) ? idle_cnt + 1'b1 : '0;
      if (state == SLEEP)     wake_cnt <= WCW'(WAKE_CYCLES - 1);
      else if (state == WAKE) wake_cnt <= wake_cnt - 1'b1;
    end
  end
`else
  // Sleep is compiled out; this is constant 0 for any legal configuration.
  assign grant_ok  = 1'b1;
  assign mem_sleep = (SLEEP_IDLE < 0) && (WAKE_CYCLES < 0);
`endif

endmodule

// File: doc/uram_port_arbiter.md
Name: uram_port_arbiter

Overview:
Round-robin arbiter sharing one port of a single-clock URAM288 (one clock, NO_CHANGE mode, configurable output latency) among NUM_REQ requesters. Each cycle it grants at most one request, drives the URAM port, and routes read data back tagged with the requester index. It sits between the client engines and the URAM288 instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AWIDTH, 12, URAM address width
DWIDTH, 72, data width (9 byte lanes)
MEM_LATENCY, 1, URAM LATENCY_A setting (0..4); read data returns MEM_LATENCY+1 cycles after grant
SLEEP_IDLE, 64, idle cycles before sleep (used only with the optional feature)
WAKE_CYCLES, 2, grant-blocking cycles after sleep exit (used only with the optional feature)

Ports:
clk  in  1  clock; also drives the URAM clka
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request valid
req_we  in  NUM_REQ  1 = write, 0 = read
req_be  in  NUM_REQ*9  byte-lane enables, one 9-bit slice per requester
req_addr  in  NUM_REQ*AWIDTH  request address slices
req_wdata  in  NUM_REQ*DWIDTH  write data slices
gnt  out  NUM_REQ  one-hot grant; the request is accepted in the same cycle
rsp_valid  out  1  read data valid
rsp_id  out  $clog2(NUM_REQ)  requester index owning rsp_data
rsp_data  out  DWIDTH  read data
mem_en  out  1  URAM ena
mem_we  out  9  URAM wea
mem_addr  out  AWIDTH  URAM addra
mem_din  out  DWIDTH  URAM dina
mem_dout  in  DWIDTH  URAM douta
mem_sleep  out  1  URAM sleep

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_id=0, mem_en=0, mem_we=0, mem_sleep=0. The RR pointer resets to requester 0. The tag pipeline is cleared.
- Handshake: a requester holds req and its fields stable until it sees gnt in the same cycle. gnt is combinational from req and the registered RR pointer. The requester may drop req or present a new request in the next cycle.
- Arbitration: the search starts at the RR pointer. The first asserted req at or above the pointer, wrapping modulo NUM_REQ, wins. The pointer moves to winner+1, wrapping to 0. The pointer holds when there is no grant.
- Memory drive: mem_en, mem_we, mem_addr and mem_din are combinational from the winner.
  - mem_we = req_be slice when req_we=1, otherwise 0.
  - A write with be=0 is still granted; mem_en=1 and no lanes are written.
- Read return: a granted read pushes {valid, id} into a shift pipeline of depth MEM_LATENCY+1. rsp_valid and rsp_id come from the last stage. rsp_data = mem_dout, passed combinationally.
  - Read granted at cycle T → rsp_valid=1 at cycle T+MEM_LATENCY+1.
  - Reads from different requesters may be back-to-back; responses come out in grant order, one per cycle.
  - There is no response backpressure. Requesters must always accept.
- Writes: completion is gnt itself. Writes produce no response. The URAM is in NO_CHANGE mode, so a write does not disturb data from an earlier read still in flight.
- Read-after-write to the same address in consecutive grants returns the new data.
- rst_n asserted mid-operation: the pipeline is flushed and in-flight responses are dropped (rsp_valid=0 immediately). The URAM contents are not affected.

Optional Feature:
URAM_ARB_SLEEP_EN.
- Defined: an idle counter counts cycles with req==0 and the tag pipeline empty.
  - When the count reaches SLEEP_IDLE, mem_sleep goes to 1 (state SLEEP).
  - Any req in SLEEP sets mem_sleep=0 and enters WAKE for WAKE_CYCLES cycles. gnt is forced to 0 during WAKE.
  - After WAKE the block returns to ACTIVE and normal arbitration resumes, with the RR pointer unchanged.
  - Any grant resets the idle counter.
- Undefined: mem_sleep is tied 0, there is no counter or FSM, and the SLEEP_IDLE and WAKE_CYCLES parameters are ignored.

Decomposition:
- Package uram_arb_pkg holds:
  - URAM_BE_W=9 and URAM_DW=72 constants;
  - the arb_state_e enum (ACTIVE, SLEEP, WAKE);
  - a clog2-based index-width function.
- One sub-module: rr_pick (round-robin priority picker, NUM_REQ wide, combinational pick plus registered pointer). The tag pipeline and sleep FSM stay in the top level.

Test Plan:
- Fairness: NUM_REQ=4, all req held high for 8 cycles → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Read latency: MEM_LATENCY=1. Requester 2 writes 0x..A5 to addr 0x010 with be=0x1FF, then reads 0x010 → rsp_valid 2 cycles after the read grant, rsp_id=2, rsp_data=write value.
- Byte enable: write all-ones to addr 0x020, then write zeros with be=0x001, then read → data = 0xFF...FF00.
- Interleaved reads: requesters 1 and 3 issue reads to different addresses with MEM_LATENCY=3 → two consecutive rsp_valid cycles with ids 1,3 and the correct data each.
- Reset mid-flight: assert rst_n=0 one cycle after a read grant → rsp_valid never rises for that read; after release gnt follows the pointer from requester 0.
- Sleep (URAM_ARB_SLEEP_EN, SLEEP_IDLE=8, WAKE_CYCLES=2): idle 8 cycles → mem_sleep=1. Raise req[0] → mem_sleep=0 that cycle, gnt=0 for 2 cycles, then gnt[0]=1.
